// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared widths, field-width derivations and ext_mode encoding for the decode stage
package instr_pkg;

  localparam int DEF_INSTR_W = 32;
  localparam int DEF_OP_W    = 6;
  localparam int DEF_REG_W   = 5;
  localparam int DEF_XLEN    = 32;

  function automatic int calc_fn_w(input int instr_w, input int op_w, input int reg_w);
    return instr_w - op_w - 3 * reg_w;
  endfunction

  function automatic int calc_off_w(input int reg_w, input int fn_w);
    return reg_w + fn_w;
  endfunction

  function automatic int calc_imm_w(input int reg_w, input int fn_w);
    return 2 * reg_w + fn_w;
  endfunction

  function automatic int calc_jtr_w(input int instr_w, input int op_w);
    return instr_w - op_w;
  endfunction

  localparam int DEF_FN_W  = calc_fn_w(DEF_INSTR_W, DEF_OP_W, DEF_REG_W);
  localparam int DEF_OFF_W = calc_off_w(DEF_REG_W, DEF_FN_W);
  localparam int DEF_IMM_W = calc_imm_w(DEF_REG_W, DEF_FN_W);
  localparam int DEF_JTR_W = calc_jtr_w(DEF_INSTR_W, DEF_OP_W);

  typedef enum logic [1:0] {
    EXT_ZERO     = 2'd0,
    EXT_SIGN_OFF = 2'd1,
    EXT_SIGN_IMM = 2'd2,
    EXT_JUMP     = 2'd3
  } ext_mode_e;

endpackage

// File: rtl/instr_field_split.sv
// rtl/instr_field_split.sv - combinational field slicing and immediate extension of one instruction word
module instr_field_split
  import instr_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int REG_W   = DEF_REG_W,
  parameter int XLEN    = DEF_XLEN,
  localparam int FN_W   = calc_fn_w(INSTR_W, OP_W, REG_W),
  localparam int OFF_W  = calc_off_w(REG_W, FN_W),
  localparam int IMM_W  = calc_imm_w(REG_W, FN_W),
  localparam int JTR_W  = calc_jtr_w(INSTR_W, OP_W)
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [1:0]         ext_mode,
  output logic [OP_W-1:0]    op,
  output logic [REG_W-1:0]   rs,
  output logic [REG_W-1:0]   rt,
  output logic [REG_W-1:0]   sh,
  output logic [FN_W-1:0]    fn,
  output logic [OFF_W-1:0]   offset,
  output logic [IMM_W-1:0]   imm,
  output logic [JTR_W-1:0]   jtr,
  output logic [XLEN-1:0]    imm_ext
);

  assign op     = instr[INSTR_W-1 -: OP_W];
  assign rs     = instr[INSTR_W-OP_W-1 -: REG_W];
  assign rt     = instr[INSTR_W-OP_W-REG_W-1 -: REG_W];
  assign sh     = instr[INSTR_W-OP_W-2*REG_W-1 -: REG_W];
  assign fn     = instr[FN_W-1:0];
  assign offset = {sh, fn};
  assign imm    = {rt, offset};
  assign jtr    = {rs, imm};

  // Size casts of signed operands sign-extend; jump targets are word addresses.
  always_comb begin
    imm_ext = XLEN'(offset);
    case (ext_mode_e'(ext_mode))
      EXT_ZERO:     imm_ext = XLEN'(offset);
      EXT_SIGN_OFF: imm_ext = XLEN'($signed(offset));
      EXT_SIGN_IMM: imm_ext = XLEN'($signed(imm));
      EXT_JUMP:     imm_ext = XLEN'({jtr, 2'b00});
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - decode stage: field split on write into a 2-entry FIFO with valid/ready handshakes
module instr_decode_stage
  import instr_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int REG_W   = DEF_REG_W,
  parameter int XLEN    = DEF_XLEN,
  localparam int FN_W   = calc_fn_w(INSTR_W, OP_W, REG_W),
  localparam int OFF_W  = calc_off_w(REG_W, FN_W),
  localparam int IMM_W  = calc_imm_w(REG_W, FN_W),
  localparam int JTR_W  = calc_jtr_w(INSTR_W, OP_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [1:0]         ext_mode,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    op,
  output logic [REG_W-1:0]   rs,
  output logic [REG_W-1:0]   rt,
  output logic [REG_W-1:0]   sh,
  output logic [FN_W-1:0]    fn,
  output logic [OFF_W-1:0]   offset,
  output logic [IMM_W-1:0]   imm,
  output logic [JTR_W-1:0]   jtr,
  output logic [XLEN-1:0]    imm_ext,
  output logic [15:0]        decoded_cnt
);

  logic [OP_W-1:0]  w_op;
  logic [REG_W-1:0] w_rs, w_rt, w_sh;
  logic [FN_W-1:0]  w_fn;
  logic [OFF_W-1:0] w_offset;
  logic [IMM_W-1:0] w_imm;
  logic [JTR_W-1:0] w_jtr;
  logic [XLEN-1:0]  w_imm_ext;

  instr_field_split #(
    .INSTR_W (INSTR_W),
    .OP_W    (OP_W),
    .REG_W   (REG_W),
    .XLEN    (XLEN)
  ) u_split (
    .instr    (instr),
    .ext_mode (ext_mode),
    .op       (w_op),
    .rs       (w_rs),
    .rt       (w_rt),
    .sh       (w_sh),
    .fn       (w_fn),
    .offset   (w_offset),
    .imm      (w_imm),
    .jtr      (w_jtr),
    .imm_ext  (w_imm_ext)
  );

  logic [OP_W-1:0]  op_mem     [2];
  logic [REG_W-1:0] rs_mem     [2];
  logic [REG_W-1:0] rt_mem     [2];
  logic [REG_W-1:0] sh_mem     [2];
  logic [FN_W-1:0]  fn_mem     [2];
  logic [OFF_W-1:0] offset_mem [2];
  logic [IMM_W-1:0] imm_mem    [2];
  logic [JTR_W-1:0] jtr_mem    [2];
  logic [XLEN-1:0]  ext_mem    [2];

  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       push;
  logic       pop;

  // Both flags depend on the registered count only, so out_ready never reaches in_ready.
  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]     <= w_op;
      rs_mem[wr_ptr]     <= w_rs;
      rt_mem[wr_ptr]     <= w_rt;
      sh_mem[wr_ptr]     <= w_sh;
      fn_mem[wr_ptr]     <= w_fn;
      offset_mem[wr_ptr] <= w_offset;
      imm_mem[wr_ptr]    <= w_imm;
      jtr_mem[wr_ptr]    <= w_jtr;
      ext_mem[wr_ptr]    <= w_imm_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      decoded_cnt <= 16'd0;
    end else begin
      if (pop) begin
        decoded_cnt <= decoded_cnt + 16'd1;
      end
      if (flush) begin
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  assign op      = op_mem[rd_ptr];
  assign rs      = rs_mem[rd_ptr];
  assign rt      = rt_mem[rd_ptr];
  assign sh      = sh_mem[rd_ptr];
  assign fn      = fn_mem[rd_ptr];
  assign offset  = offset_mem[rd_ptr];
  assign imm     = imm_mem[rd_ptr];
  assign jtr     = jtr_mem[rd_ptr];
  assign imm_ext = ext_mem[rd_ptr];

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 Parameter INSTR_W, default 32, instruction word width.
REQ-002 Parameter OP_W, default 6, opcode field width.
REQ-003 Parameter REG_W, default 5, width of each of the rs, rt and sh fields.
REQ-004 Parameter XLEN, default 32, width of the extended immediate; XLEN SHALL be at least INSTR_W-OP_W+2.
REQ-005 Derived FN_W = INSTR_W-OP_W-3*REG_W (11 at defaults); OFF_W = REG_W+FN_W; IMM_W = 2*REG_W+FN_W; JTR_W = INSTR_W-OP_W.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 in_valid  input  1  an instruction is offered.
REQ-009 in_ready  output  1  the stage can accept an instruction.
REQ-010 instr  input  INSTR_W  raw instruction word.
REQ-011 ext_mode  input  2  immediate extension mode, sampled together with instr.
REQ-012 flush  input  1  discard all buffered instructions.
REQ-013 out_valid  output  1  the decoded head entry is valid.
REQ-014 out_ready  input  1  the consumer accepts the head entry.
REQ-015 op, rs, rt, sh, fn  outputs  OP_W, REG_W, REG_W, REG_W, FN_W  fields of the head entry.
REQ-016 offset, imm, jtr  outputs  OFF_W, IMM_W, JTR_W  concatenated fields {sh,fn}, {rt,offset} and {rs,imm}.
REQ-017 imm_ext  output  XLEN  extended immediate of the head entry.
REQ-018 decoded_cnt  output  16  count of instructions consumed at the output.

Function
REQ-019 Field slicing SHALL be: op = top OP_W bits; rs, rt and sh = the next three REG_W slices in descending order; fn = the remaining low bits.
REQ-020 imm_ext SHALL be selected by ext_mode: 0 = zero-extended offset; 1 = sign-extended offset; 2 = sign-extended imm; 3 = {jtr,2'b00} zero-extended.
REQ-021 The stage SHALL hold a 2-entry FIFO; each entry SHALL store the sliced fields, offset, imm, jtr and imm_ext, all computed at write time.
REQ-022 A push SHALL occur when in_valid and in_ready are both high; a pop SHALL occur when out_valid and out_ready are both high.
REQ-023 Latency SHALL be one cycle: an instruction pushed into an empty FIFO at edge N SHALL be presented with out_valid high after edge N.
REQ-024 in_ready SHALL be high exactly when the entry count is below 2, and SHALL be registered-state-only, with no combinational path from out_ready.
REQ-025 out_valid SHALL be high exactly when the count is nonzero; outputs SHALL always reflect the head entry and SHALL remain stable while out_valid is high and out_ready is low.
REQ-026 Push and pop in the same cycle with count 1 SHALL leave count at 1, with the new entry at the head.
REQ-027 Push and pop in the same cycle with count 2 SHALL NOT occur, because in_ready is low; the pop alone SHALL reduce count to 1.
REQ-028 Read and write pointers SHALL each be 1 bit and wrap from 1 to 0.
REQ-029 flush SHALL clear count and both pointers at the next edge, with priority over a simultaneous push or pop; a flushed push is lost and SHALL NOT be counted.
REQ-030 decoded_cnt SHALL increment by 1 per pop, wrapping from 0xFFFF to 0x0000, and SHALL be unaffected by flush.

Reset
REQ-031 While rst_n is low, count, pointers and decoded_cnt SHALL be 0, out_valid SHALL be 0 and in_ready SHALL be 1, all taking effect immediately without a clock edge.
REQ-032 Entry storage SHALL NOT require reset; field outputs SHALL be don't-care while out_valid is low.
REQ-033 Reset asserted mid-transfer SHALL discard all entries; after deassertion, the first accepted instruction SHALL appear one cycle later.

Structure
REQ-034 A shared package instr_pkg SHALL hold the default widths, the FN_W, OFF_W, IMM_W and JTR_W derivations, and the ext_mode enumeration (EXT_ZERO, EXT_SIGN_OFF, EXT_SIGN_IMM, EXT_JUMP).
REQ-035 Slicing and extension SHALL reside in one combinational sub-module, instr_field_split, instantiated on the write path; FIFO and control logic SHALL reside in the top module.

Verification
REQ-036 Push 0x8C221234 with ext_mode 1 into an empty stage, out_ready=1 -> next cycle op=0x23, rs=1, rt=2, sh=2, fn=0x234, offset=0x1234, imm_ext=0x00001234; decoded_cnt=1 after the pop.
REQ-037 Push 0x00008000 with ext_mode 1 -> imm_ext=0xFFFF8000; same word with ext_mode 0 -> imm_ext=0x00008000; 0x0BFFFFFF with ext_mode 3 -> jtr=0x3FFFFFF, imm_ext=0x0FFFFFFC.
REQ-038 out_ready=0, push A then B -> in_ready low after the second push and a third offer is refused; raise out_ready -> A then B delivered in order, in_ready high after the first pop.
REQ-039 Count 1, simultaneous push C and pop -> count stays 1 and the head becomes C; pointers wrap with no lost or duplicated entry over 10 back-to-back instructions.
REQ-040 Count 2, flush together with in_valid -> out_valid=0 and count=0 next cycle, the offered word is dropped, and decoded_cnt is unchanged.
REQ-041 Assert rst_n low asynchronously mid-stream -> out_valid=0, in_ready=1 and decoded_cnt=0 immediately; normal flow resumes after release.
